ps2_scancode_rx: RTL and testbench

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_scancode_rx.sv | 128 ++++++++++++
 tb/tb_ps2_scancode_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for ps2_clk/ps2_data plus ps2_clk falling-edge detection.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Everything resets high (bus idle level) so reset release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign data_sync = data_sync_q;
    assign fall      = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver producing scancode bytes with break-prefix qualification.
// Optional build macro PS2_PARITY_CHECK_EN enables rejection of frames with bad parity.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       brk,
    output logic [3:0] hex_hi,
    output logic [3:0] hex_lo,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic data_s, fall;

    ps2_sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_s),
        .fall     (fall)
    );

    ps2_state_e       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [7:0]       code_q;
    logic             code_valid_q, frame_err_q, brk_q, f0_q;
    logic             good, bad, parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{parity_q, shift_q};
`else
    // Parity is still captured so the frame layout is tracked, but it never rejects.
    logic unused_parity;
    assign unused_parity = parity_q;
    assign parity_ok     = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        good      = 1'b0;
        bad       = 1'b0;
        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && parity_ok) good = 1'b1;
                    else                     bad  = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && idle_cnt_q == CNT_MAX) begin
            state_d = StIdle;
            bad     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            idle_cnt_q   <= '0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
            f0_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            code_valid_q <= good;
            frame_err_q  <= bad;
            brk_q        <= good & f0_q;
            if (fall)                       idle_cnt_q <= '0;
            else if (idle_cnt_q != CNT_MAX) idle_cnt_q <= idle_cnt_q + 1'b1;
            // Only accepted bytes touch the prefix flag; rejected frames leave it pending.
            if (good) begin
                code_q <= shift_q;
                f0_q   <= (shift_q == BREAK_CODE);
            end
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign brk        = brk_q;
    assign hex_hi     = code_q[7:4];
    assign hex_lo     = code_q[3:0];

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx: frame table plus timeout and reset sequences.
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 100;
    localparam int HALF    = 20;
    localparam int NVEC    = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid, brk, frame_err;
    logic [3:0] hex_hi, hex_lo;

    ps2_scancode_rx #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .code_valid(code_valid),
        .brk       (brk),
        .hex_hi    (hex_hi),
        .hex_lo    (hex_lo),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int n_err = 0;
    int strobe_cyc = 0;
    int edge_cyc = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_brk = 1'b0;

    always @(negedge clk) begin
        if (code_valid) begin
            n_valid++;
            last_code  = code;
            last_brk   = brk;
            strobe_cyc = cyc;
        end
        if (frame_err) begin
            n_err++;
            strobe_cyc = cyc;
        end
        if (brk && !code_valid) begin
            fails++;
            $display("FAIL brk_without_valid: brk=1 while code_valid=0 at cycle %0d", cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends bits [0..nbits-1] of {stop, parity, data, start}; edge_cyc marks the last falling edge.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #2;
            ps2_data = bits[i];
            repeat (HALF / 2) @(posedge clk);
            #2;
            ps2_clk  = 1'b0;
            edge_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #2;
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(posedge clk);
        end
        #2;
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_bits({stop, par, data, 1'b0}, 11);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_code;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0;
        logic par;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0};
`else
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0};
`endif
        vecs[4] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0};
        vecs[5] = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29, 1'b0};
        vecs[6] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[7] = '{8'h74, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};
        vecs[8] = '{8'h74, 1'b0, 1'b1, 1'b1, 1'b0, 8'h74, 1'b1};

        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_code", 32'(code), 32'h00);
        check("reset_hex_hi", 32'(hex_hi), 32'h0);
        check("reset_hex_lo", 32'(hex_lo), 32'h0);
        check("reset_strobes", 32'(n_valid + n_err), 32'd0);
        check("reset_brk", 32'(brk), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            v0  = n_valid;
            e0  = n_err;
            par = ~(^vecs[i].data) ^ vecs[i].par_flip;
            send_frame(vecs[i].data, par, vecs[i].stop);
            repeat (20) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_valid_cnt", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_err_cnt", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_hex_hi", i), 32'(hex_hi), 32'(vecs[i].exp_code[7:4]));
            check($sformatf("v%0d_hex_lo", i), 32'(hex_lo), 32'(vecs[i].exp_code[3:0]));
            check($sformatf("v%0d_latency", i), 32'(strobe_cyc - edge_cyc), 32'd3);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_strobe_code", i), 32'(last_code), 32'(vecs[i].exp_code));
                check($sformatf("v%0d_brk", i), 32'(last_brk), 32'(vecs[i].exp_brk));
            end
        end

        // Stall after start + 4 data bits of 8'h5A.
        v0 = n_valid;
        e0 = n_err;
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
        repeat (3 * TIMEOUT) @(posedge clk);
        @(negedge clk);
        check("timeout_err_cnt", 32'(n_err - e0), 32'd1);
        check("timeout_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("timeout_latency", 32'(strobe_cyc - edge_cyc), 32'(TIMEOUT + 3));
        check("timeout_code_held", 32'(code), 32'h74);
        v0 = n_valid;
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("after_timeout_valid", 32'(n_valid - v0), 32'd1);
        check("after_timeout_code", 32'(code), 32'h5A);
        check("after_timeout_brk", 32'(last_brk), 32'd0);

        // Reset in the middle of a frame.
        v0 = n_valid;
        e0 = n_err;
        send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 1);
        #2 rst = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3 * TIMEOUT) @(posedge clk);
        @(negedge clk);
        check("midreset_strobes", 32'(n_valid - v0 + n_err - e0), 32'd0);
        check("midreset_code", 32'(code), 32'h00);
        check("midreset_hex_hi", 32'(hex_hi), 32'h0);
        send_frame(8'h45, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("after_reset_valid", 32'(n_valid - v0), 32'd1);
        check("after_reset_err", 32'(n_err - e0), 32'd0);
        check("after_reset_code", 32'(code), 32'h45);
        check("after_reset_hex_hi", 32'(hex_hi), 32'h4);
        check("after_reset_hex_lo", 32'(hex_lo), 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
